// File: rtl/mux_pkg.sv
// Shared constants for the operand-source selector pipeline.
package mux_pkg;

  // Default data width follows the register bus.
  localparam int REGBUS_W = 32;

  // Supported range for the number of selectable sources.
  localparam int MIN_SRC = 2;
  localparam int MAX_SRC = 16;

endpackage : mux_pkg

// File: rtl/mux_nsel.sv
// Purely combinational N:1 source mux with an illegal-select flag.
// An out-of-range select (only reachable when NUM_SRC is not a power
// of two) yields zero data and raises o_illegal.
module mux_nsel
  import mux_pkg::*;
#(
  parameter int WIDTH   = REGBUS_W,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [NUM_SRC*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_illegal
);

  // One extra bit so NUM_SRC itself is representable for the compare.
  localparam logic [SEL_W:0] SRC_CNT = (SEL_W+1)'(NUM_SRC);

  logic w_illegal;

  assign w_illegal = ({1'b0, i_sel} >= SRC_CNT);
  assign o_illegal = w_illegal;
  // Gating with w_illegal keeps the part-select from reaching past the bus.
  assign o_data    = w_illegal ? {WIDTH{1'b0}} : i_data[i_sel*WIDTH +: WIDTH];

endmodule : mux_nsel

// File: rtl/mux_src_pipe.sv
// Registered N:1 operand-source selector with valid/ready handshake.
// A main register drives out_*; a one-entry skid register absorbs the
// input accepted in the cycle the downstream stalls, so nothing is lost.
// in_ready comes straight from a flop and equals "skid empty".
module mux_src_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH   = REGBUS_W,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     sel_err,
  input  logic                     err_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] src;
  } entry_t;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_illegal;
  entry_t           w_in_entry;
  logic             w_acc;
  logic             w_xfer;

  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;
  logic   r_in_ready;
  logic   r_sel_err;

  entry_t w_main_nxt;
  entry_t w_skid_nxt;
  logic   w_main_valid_nxt;
  logic   w_skid_valid_nxt;
  logic   w_sel_err_nxt;

  mux_nsel #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux_nsel (
    .i_sel     (in_sel),
    .i_data    (in_data),
    .o_data    (w_sel_data),
    .o_illegal (w_sel_illegal)
  );

  assign w_acc  = in_valid && r_in_ready;
  assign w_xfer = r_main_valid && out_ready;

  // Pack the selected data with the select that produced it.
  always_comb begin
    w_in_entry      = '0;
    w_in_entry.data = w_sel_data;
    w_in_entry.src  = in_sel;
  end

  // Next main/skid contents: flush first, then refill main, else fill skid.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      // Data is left in place; it is don't-care once valid drops.
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || w_xfer) begin
      if (r_skid_valid) begin
        // in_ready is low here, so no accept can collide with this move.
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_acc) begin
        w_main_nxt       = w_in_entry;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else begin
      if (w_acc) begin
        w_skid_nxt       = w_in_entry;
        w_skid_valid_nxt = 1'b1;
      end else begin
        w_skid_valid_nxt = r_skid_valid;
      end
    end
  end

  // Sticky illegal-select flag: a new illegal accept beats a clear.
  always_comb begin
    w_sel_err_nxt = r_sel_err;
    if (w_acc && w_sel_illegal) begin
      w_sel_err_nxt = 1'b1;
    end else if (err_clr) begin
      w_sel_err_nxt = 1'b0;
    end else begin
      w_sel_err_nxt = r_sel_err;
    end
  end

  // State registers; in_ready stays low in reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      r_sel_err    <= w_sel_err_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main.data;
  assign out_src   = r_main.src;
  assign sel_err   = r_sel_err;

endmodule : mux_src_pipe

// File: doc/mux_src_pipe.md
Name: mux_src_pipe

Overview:
- Parametrised, registered N:1 operand-source selector for the execute/mov datapath. Generalises the 2:1 combinational source mux.
- Selects one of NUM_SRC register-bus-wide inputs by a binary select and registers the result.
- Uses a valid/ready handshake with a 2-entry skid buffer, so pipeline stalls never drop data.
- Adds a flush input and a sticky illegal-select error flag.

Parameters:
- WIDTH, 32, data width per source; matches RegBus width.
- NUM_SRC, 4, number of selectable sources (2..16).
- SEL_W, $clog2(NUM_SRC), select width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a select/data set.
- in_ready  output  1  block can accept this cycle.
- in_sel  input  SEL_W  binary source index.
- in_data  input  NUM_SRC*WIDTH  packed sources; source k at bits [k*WIDTH +: WIDTH].
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  out_data/out_src valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  selected data.
- out_src  output  SEL_W  index that produced out_data.
- sel_err  output  1  sticky: an illegal select was accepted.
- err_clr  input  1  clears sel_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_src=0, sel_err=0.
  - Skid entry empty; in_ready=1 one edge after rst deasserts (in_ready = !skid_valid, driven from a flop).
- Accept occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Latency and throughput:
  - Latency 1 cycle: an input accepted at edge N appears on out_* after edge N.
  - Throughput is 1 per cycle while out_ready=1.
- Select function:
  - sel_data = in_data[in_sel] if in_sel < NUM_SRC.
  - Otherwise sel_data = 0 and the entry is marked illegal. This only applies when NUM_SRC is not a power of 2.
- Storage is a main register (feeding out_*) plus a skid register:
  - Main empty or transferring, skid empty: an accepted input loads main.
  - Main full and not transferring: an accepted input loads skid; in_ready drops the next cycle.
  - Main transferring, skid full: skid moves to main. A simultaneous accept is impossible because in_ready=0.
  - No accept and main transferring: main becomes empty (out_valid=0).
- out_* hold stable while out_valid=1 and out_ready=0. The bench checks this.
- Flush:
  - flush=1 at an edge clears main and skid valid; out_valid=0 and in_ready=1 after that edge.
  - An input presented in the flush cycle is dropped.
  - flush overrides every other transition.
  - out_data/out_src are not cleared by flush; they are don't-care while out_valid=0.
- sel_err:
  - Set at the edge where an illegal select is accepted, including during flush.
  - Cleared by err_clr; set wins if both occur in the same cycle.
- Any order of in_valid/out_ready toggling must neither lose nor duplicate entries. At most 2 entries are in flight.

Decomposition:
- Package mux_pkg holds:
  - the default WIDTH tied to the RegBus width;
  - localparam MAX_SRC=16;
  - typedef struct {logic [WIDTH-1:0] data; logic [SEL_W-1:0] src;} for the entry (parameterised via the module localparam).
- One sub-module: mux_nsel, a purely combinational parametrised N:1 mux (WIDTH, NUM_SRC) with an illegal-select output. mux_src_pipe instantiates it once ahead of the main/skid registers.

Test Plan:
- Reset with out_ready=1; send sel=2, in_data sources {0x11,0x22,0x33,0x44} -> one cycle later out_valid=1, out_data=0x33, out_src=2; sel_err=0.
- Stream sel=0,1,2,3 back-to-back with out_ready=1 -> outputs 0x11,0x22,0x33,0x44 on consecutive cycles; in_ready stays 1.
- Hold out_ready=0 and send 3 inputs -> the first two are accepted, then in_ready=0 and out_data holds the first value; raise out_ready -> the first two are delivered in order, then the third is accepted.
- NUM_SRC=3 and send sel=3 -> out_data=0, out_src=3, sel_err=1 and stays set; err_clr=1 in the same cycle as another illegal accept -> sel_err remains 1; err_clr alone -> sel_err=0.
- Fill main and skid (out_ready=0), then assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Assert rst low mid-stream, asynchronously between edges -> out_valid and sel_err go 0 immediately; after release, normal acceptance resumes.
